// File: rtl/mioc_pkg.sv
// Shared types and constants for the MIOC CPU-side bus responder.

package mioc_pkg;

    localparam int unsigned REG_W = 8;
    localparam logic [2:0] STATUS_ADDR = 3'd7;

    typedef enum logic [2:0] {
        StIdle,
        StDecode,
        StWait,
        StAck,
        StHold
    } mioc_state_e;

    // Parity bit that makes {d, bit} carry an odd number of ones.
    function automatic logic odd_parity(input logic [REG_W-1:0] d);
        return ~^d;
    endfunction

endpackage

// File: rtl/mioc_sticky_status.sv
// Set-dominant sticky status bits with a per-bit clear mask; updates on the falling clock edge.

module mioc_sticky_status
    import mioc_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [REG_W-1:0] set_i,
    input  logic [REG_W-1:0] clr_i,
    output logic [REG_W-1:0] status_o
);

    logic [REG_W-1:0] status_q, status_d;

    // An event arriving in the same cycle as a clear wins, so no pulse is lost.
    always_comb begin
        status_d = (status_q & ~clr_i) | set_i;
    end

    always_ff @(negedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            status_q <= '0;
        end else begin
            status_q <= status_d;
        end
    end

    assign status_o = status_q;

endmodule

// File: rtl/mioc_bus_responder.sv
// MIOC CPU-side register responder: decode, programmable wait states, ack, control/status regs.
// Optional rpar_o read-data parity output is built when MIOC_RESP_PARITY_EN is defined.

module mioc_bus_responder
    import mioc_pkg::*;
#(
    parameter int unsigned      WAIT_STATES = 2,
    parameter int unsigned      NREGS       = 4,
    parameter logic [REG_W-1:0] RESET_CTRL  = 8'h00
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   cs_i,
    input  logic                   rw_i,
    input  logic [2:0]             addr_i,
    input  logic [REG_W-1:0]       wdata_i,
    input  logic [REG_W-1:0]       evt_i,
    output logic [REG_W-1:0]       rdata_o,
    output logic                   rdata_oe_o,
    output logic                   ack_o,
`ifdef MIOC_RESP_PARITY_EN
    output logic                   rpar_o,
`endif
    output logic [REG_W*NREGS-1:0] ctrl_o
);

    if (WAIT_STATES > 7) begin : g_bad_wait
        $error("mioc_bus_responder: WAIT_STATES must be in 0..7");
    end
    if (NREGS < 1 || NREGS > 7) begin : g_bad_nregs
        $error("mioc_bus_responder: NREGS must be in 1..7");
    end

    localparam logic [2:0] WAIT_LAST = 3'(WAIT_STATES - 1);

    mioc_state_e                        state_q, state_d;
    logic [2:0]                         cnt_q, cnt_d;
    logic                               rw_q, rw_d;
    logic [2:0]                         addr_q, addr_d;
    logic [REG_W-1:0]                   wdata_q, wdata_d;
    logic [REG_W-1:0]                   rdata_q, rdata_d;
    logic [NREGS-1:0][REG_W-1:0]        ctrl_q, ctrl_d;
    logic [REG_W-1:0]                   status;
    logic [REG_W-1:0]                   status_clr;
    logic [REG_W-1:0]                   rd_val;

    mioc_sticky_status u_status (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .set_i    (evt_i),
        .clr_i    (status_clr),
        .status_o (status)
    );

    always_comb begin
        rd_val = '0;
        if (addr_q == STATUS_ADDR) begin
            rd_val = status;
        end else begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                if (addr_q == 3'(i)) begin
                    rd_val = ctrl_q[i];
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rw_d    = rw_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        ctrl_d  = ctrl_q;
        rdata_d = '0;
        unique case (state_q)
            StIdle: begin
                if (cs_i) begin
                    state_d = StDecode;
                    rw_d    = rw_i;
                    addr_d  = addr_i;
                    wdata_d = wdata_i;
                end
            end
            StDecode: begin
                cnt_d   = '0;
                state_d = (WAIT_STATES > 0) ? StWait : StAck;
            end
            StWait: begin
                if (cnt_q == WAIT_LAST) begin
                    state_d = StAck;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            StAck: begin
                state_d = StHold;
            end
            StHold: begin
                if (!cs_i) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Data moves on the edge entering ACK so rdata/ctrl are settled while ack is high.
        if (state_d == StAck) begin
            if (rw_q) begin
                rdata_d = rd_val;
            end else begin
                for (int unsigned i = 0; i < NREGS; i++) begin
                    if (addr_q == 3'(i)) begin
                        ctrl_d[i] = wdata_q;
                    end
                end
            end
        end
    end

    // Only the bits actually returned are cleared, at the edge that ends the ACK cycle.
    assign status_clr = (state_q == StAck && rw_q && addr_q == STATUS_ADDR) ? rdata_q : '0;

    always_ff @(negedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            rw_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            ctrl_q  <= {NREGS{RESET_CTRL}};
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rw_q    <= rw_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            ctrl_q  <= ctrl_d;
        end
    end

    assign ack_o      = (state_q == StAck);
    assign rdata_oe_o = ack_o & rw_q;
    assign rdata_o    = rdata_q;
    assign ctrl_o     = ctrl_q;

`ifdef MIOC_RESP_PARITY_EN
    assign rpar_o = rdata_oe_o & odd_parity(rdata_q);
`else
    // Without the parity option rdata is returned unprotected.
`endif

endmodule
